// File: rtl/mem_responder.sv
// mem_responder: single-outstanding word memory with programmable wait states and range checking
module mem_responder #(
  parameter int n = 16,
  parameter int depth_log2 = 8,
  parameter int wait_cycles = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req,
  input  logic         memwrite,
  input  logic [n-1:0] addr,
  input  logic [n-1:0] wdata,
  output logic [n-1:0] rdata,
  output logic         ready,
  output logic         busy,
  output logic         err
);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t state, state_n;
  logic [3:0] count;
  logic wr_q;
  logic [n-1:0] addr_q, wdata_q;
  logic [n-1:0] mem [2**depth_log2];
  logic [n-1:0] cur_addr;
  logic cur_wr, in_range;
  logic [depth_log2-1:0] idx;
  // with zero wait states RESP is entered on the accept edge, so decode the live inputs then
  always_comb begin
    cur_addr = state == IDLE ? addr : addr_q;
    cur_wr = state == IDLE ? memwrite : wr_q;
    in_range = cur_addr[n-1:depth_log2] == '0;
    idx = cur_addr[depth_log2-1:0];
    state_n = state == IDLE ? (req ? (wait_cycles == 0 ? RESP : WAIT) : IDLE)
            : state == WAIT ? (count == 4'd1 ? RESP : WAIT) : IDLE;
  end
  assign ready = state == RESP;
  assign busy = state != IDLE;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      count <= '0;
      rdata <= '0;
      err <= 1'b0;
    end else begin
      state <= state_n;
      if (state == IDLE && req) begin
        wr_q <= memwrite;
        addr_q <= addr;
        wdata_q <= wdata;
        count <= 4'(wait_cycles);
      end else if (state == WAIT) count <= count - 4'd1;
      if (state_n == RESP) begin
        err <= !in_range;
        if (!cur_wr) rdata <= in_range ? mem[idx] : '0;
      end
    end
  end
  always_ff @(posedge clk)
    if (!reset && state == RESP && wr_q && in_range) mem[idx] <= wdata_q;
endmodule
